serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes D = A - B - Bin over WIDTH clock cycles, LSB first, with a single borrow flip-flop.
- It is the subtraction counterpart to the team's ripple half/full adder cells.
- Intended for area-constrained datapaths where one operation per WIDTH+1 cycles is sufficient.
- Uses a start/busy/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request; sampled only when busy_out=0.
- A_in  input  WIDTH  minuend; captured on the accepting edge.
- B_in  input  WIDTH  subtrahend; captured on the accepting edge.
- Bin_in  input  1  borrow-in; captured on the accepting edge.
- D_out  output  WIDTH  difference, registered.
- Bout_out  output  1  borrow-out of the MSB stage, registered.
- busy_out  output  1  high while bits are being processed.
- done_out  output  1  one-cycle pulse: D_out/Bout_out newly valid.
- ovf_out  output  1  signed overflow; present only with SERSUB_OVF_EN.

Behaviour:
- Reset (rst_in=1 at an edge) forces:
  - state IDLE
  - D_out=0, Bout_out=0, busy_out=0, done_out=0, ovf_out=0
  - internal shift registers, borrow FF and bit counter cleared.
- Reset has priority over every other event, including mid-SHIFT; an aborted operation produces no done_out.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_in=1 → latch A_in, B_in, Bin_in (borrow FF ← Bin_in), counter ← 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (busy_out=1), one bit per cycle:
  - a=Areg[0], b=Breg[0], br=borrow FF.
  - d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
  - Areg, Breg shift right; d shifts into the result register MSB; counter increments.
  - After the WIDTH-th bit, go to DONE.
  - start_in is ignored in this state.
- DONE (one cycle):
  - done_out=1, busy_out=0.
  - D_out ← result register and Bout_out ← final borrow, both updated on the edge entering DONE.
  - If start_in=1 in DONE, accept new operands exactly as in IDLE and go to SHIFT (back-to-back).
  - Otherwise go to IDLE.
- Latency: accepting edge at cycle 0 → done_out high during cycle WIDTH+1. Maximum throughput is 1 result per WIDTH+1 cycles.
- D_out and Bout_out hold until the next DONE entry or reset. Changes on A_in/B_in/Bin_in after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH: Bout_out=1 iff A < B+Bin (unsigned).
- The counter is wide enough to hold WIDTH; no wrap-around within an operation.

Optional Feature:
- Macro: SERSUB_OVF_EN.
- When defined:
  - ovf_out exists and is registered alongside D_out.
  - ovf_out = (borrow into MSB stage) XOR (borrow out of MSB stage), i.e. two's-complement overflow of A - B - Bin.
  - Reset value is 0; it holds like D_out.
- When undefined: the ovf_out port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- A=0x05, B=0x03, Bin=0, start pulse at cycle 0 → busy cycles 1-8, done_out at cycle 9 only, D=0x02, Bout=0.
- A=0x03, B=0x05, Bin=0 → D=0xFE, Bout=1. A=0x00, B=0x00, Bin=1 → D=0xFF, Bout=1.
- Start A=0x10, B=0x01; at cycle 3 pulse start_in with A=0xFF, B=0xFF → ignored; single done at cycle 9, D=0x0F.
- rst_in=1 at cycle 4 of an operation → all outputs 0 next cycle, no done_out. A following start with A=0x09, B=0x04 → D=0x05.
- start_in held high continuously, first A=0x20, B=0x01, then A=0x01, B=0x02 → done_out at cycles 9 and 18, D=0x1F then 0xFF (Bout=1).
- With SERSUB_OVF_EN:
  - 0x80-0x01 → D=0x7F, Bout=0, ovf=1.
  - 0x7F-0xFF → D=0x80, Bout=1, ovf=1.
  - 0x05-0x03 → ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor, D = A - B - Bin, processed LSB first over WIDTH
//   cycles with a single borrow flip-flop. One result per WIDTH+1 cycles.
//
//   Optional feature macro: SERSUB_OVF_EN (adds the registered ovf_out port).
//
// Ports
//   clk_in    : clock, rising edge
//   rst_in    : synchronous active-high reset
//   start_in  : request, honoured in IDLE and DONE only
//   A_in      : minuend, captured on the accepting edge
//   B_in      : subtrahend, captured on the accepting edge
//   Bin_in    : borrow-in, captured on the accepting edge
//   D_out     : registered difference
//   Bout_out  : registered borrow-out of the MSB stage
//   busy_out  : high while bits are being processed
//   done_out  : one-cycle pulse, D_out/Bout_out newly valid
//   ovf_out   : registered two's-complement overflow (SERSUB_OVF_EN only)
//
// state | meaning
// IDLE  | waiting for start_in
// SHIFT | one bit per cycle, busy_out high
// DONE  | one-cycle done_out pulse; may accept a new request back-to-back

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Bin_in,
    output logic [WIDTH-1:0] D_out,
    output logic             Bout_out,
    output logic             busy_out,
    output logic             done_out
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    // Counter must be able to represent WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_bit;
    logic             bit_d;
    logic             borrow_next;

    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign bit_d       = a_reg[0] ^ b_reg[0] ^ borrow;
    assign borrow_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy_out = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_out = 1'b1;
                if (start_in) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            D_out    <= '0;
            Bout_out <= 1'b0;
        end else if (accept) begin
            a_reg   <= A_in;
            b_reg   <= B_in;
            res_reg <= '0;
            borrow  <= Bin_in;
            cnt     <= '0;
        end else if (state == SHIFT) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            res_reg <= {bit_d, res_reg[WIDTH-1:1]};
            borrow  <= borrow_next;
            cnt     <= cnt + CNT_W'(1);
            // Final bit goes straight to the output so D_out is valid in DONE.
            if (last_bit) begin
                D_out    <= {bit_d, res_reg[WIDTH-1:1]};
                Bout_out <= borrow_next;
            end
        end
    end

`ifdef SERSUB_OVF_EN
    // On the last bit, borrow is the borrow into the MSB stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovf_out <= 1'b0;
        end else if (!accept && (state == SHIFT) && last_bit) begin
            ovf_out <= borrow ^ borrow_next;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;
    logic         done;
`ifdef SERSUB_OVF_EN
    logic         ovf;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start),
        .A_in     (a),
        .B_in     (b),
        .Bin_in   (bin),
        .D_out    (d),
        .Bout_out (bout),
        .busy_out (busy),
        .done_out (done)
`ifdef SERSUB_OVF_EN
        ,
        .ovf_out  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t     m;
        logic [W:0] full;
        int       s;
        full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        m.d    = full[W-1:0];
        m.bout = full[W];
        s      = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        m.ovf  = (s > 127) || (s < -128);
        return m;
    endfunction

    // Drive a request on a falling edge; the next rising edge accepts it.
    task automatic issue_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin, input bit push);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        bin   = ibin;
        if (push) sb.push_back(model(ia, ib, ibin));
    endtask

    // Observe cycles after acceptance until done_out; returns -1 on timeout.
    task automatic wait_done(input bit hold_start, input int poke_at,
                             output int done_at, output int busy_cnt);
        done_at  = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
            if (i == 1 && !hold_start) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
            end
            if (i == poke_at) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            if (i == poke_at + 1) start = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (d !== 8'h00)   begin errors++; $display("FAIL reset_d: got %h expected 00", d); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef SERSUB_OVF_EN
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    endtask

    task automatic test_basic;
        logic [W-1:0] ta[3] = '{8'h05, 8'h03, 8'h00};
        logic [W-1:0] tb[3] = '{8'h03, 8'h05, 8'h00};
        logic         tc[3] = '{1'b0, 1'b0, 1'b1};
        int           done_at, busy_cnt;
        exp_t         e;
        for (int k = 0; k < 3; k++) begin
            issue_op(ta[k], tb[k], tc[k], 1'b1);
            wait_done(1'b0, -1, done_at, busy_cnt);
            e = sb.pop_front();
            checks++; if (done_at !== W + 1) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", k, done_at, W + 1); end
            checks++; if (busy_cnt !== W)    begin errors++; $display("FAIL basic_busy[%0d]: got %0d expected %0d", k, busy_cnt, W); end
            checks++; if (d !== e.d)         begin errors++; $display("FAIL basic_d[%0d]: got %h expected %h", k, d, e.d); end
            checks++; if (bout !== e.bout)   begin errors++; $display("FAIL basic_bout[%0d]: got %b expected %b", k, bout, e.bout); end
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse[%0d]: got done=%b busy=%b expected 0 0", k, done, busy); end
            checks++; if (d !== e.d)         begin errors++; $display("FAIL basic_hold[%0d]: got %h expected %h", k, d, e.d); end
        end
    endtask

    task automatic test_ignore_start;
        int   done_at, busy_cnt, extra;
        exp_t e;
        issue_op(8'h10, 8'h01, 1'b0, 1'b1);
        wait_done(1'b0, 3, done_at, busy_cnt);
        e = sb.pop_front();
        checks++; if (done_at !== W + 1) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", done_at, W + 1); end
        checks++; if (d !== e.d)         begin errors++; $display("FAIL ignore_d: got %h expected %h", d, e.d); end
        extra = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_reset_abort;
        int   done_at, busy_cnt, seen;
        exp_t e;
        issue_op(8'h33, 8'h11, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (d !== 8'h00)   begin errors++; $display("FAIL abort_d: got %h expected 00", d); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL abort_bout: got %b expected 0", bout); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        seen = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
        issue_op(8'h09, 8'h04, 1'b0, 1'b1);
        wait_done(1'b0, -1, done_at, busy_cnt);
        e = sb.pop_front();
        checks++; if (done_at !== W + 1) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", done_at, W + 1); end
        checks++; if (d !== e.d)         begin errors++; $display("FAIL abort_next_d: got %h expected %h", d, e.d); end
    endtask

    task automatic test_back_to_back;
        int   done_at, busy_cnt, total;
        exp_t e;
        issue_op(8'h20, 8'h01, 1'b0, 1'b1);
        wait_done(1'b1, -1, done_at, busy_cnt);
        total = done_at;
        e = sb.pop_front();
        checks++; if (total !== W + 1) begin errors++; $display("FAIL b2b_first_at: got %0d expected %0d", total, W + 1); end
        checks++; if (d !== e.d || bout !== e.bout) begin errors++; $display("FAIL b2b_first: got %h/%b expected %h/%b", d, bout, e.d, e.bout); end
        a = 8'h01;
        b = 8'h02;
        sb.push_back(model(8'h01, 8'h02, 1'b0));
        wait_done(1'b1, -1, done_at, busy_cnt);
        total = (done_at < 0) ? -1 : total + done_at;
        start = 1'b0;
        e = sb.pop_front();
        checks++; if (total !== 2 * (W + 1)) begin errors++; $display("FAIL b2b_second_at: got %0d expected %0d", total, 2 * (W + 1)); end
        checks++; if (busy_cnt !== W)        begin errors++; $display("FAIL b2b_busy: got %0d expected %0d", busy_cnt, W); end
        checks++; if (d !== e.d || bout !== e.bout) begin errors++; $display("FAIL b2b_second: got %h/%b expected %h/%b", d, bout, e.d, e.bout); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb;
        logic         rc;
        int           done_at, busy_cnt;
        exp_t         e;
        for (int k = 0; k < 10; k++) begin
            case (k)
                0: begin ra = 8'hFF; rb = 8'h00; rc = 1'b0; end
                1: begin ra = 8'h00; rb = 8'hFF; rc = 1'b1; end
                2: begin ra = 8'hFF; rb = 8'hFF; rc = 1'b1; end
                3: begin ra = 8'hAA; rb = 8'h55; rc = 1'b1; end
                default: begin ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); end
            endcase
            issue_op(ra, rb, rc, 1'b1);
            wait_done(1'b0, -1, done_at, busy_cnt);
            e = sb.pop_front();
            checks++; if (done_at !== W + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, done_at, W + 1); end
            checks++; if (d !== e.d || bout !== e.bout) begin errors++; $display("FAIL rand_result[%0d] %h-%h-%b: got %h/%b expected %h/%b", k, ra, rb, rc, d, bout, e.d, e.bout); end
`ifdef SERSUB_OVF_EN
            checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", k, ovf, e.ovf); end
`endif
        end
    endtask

`ifdef SERSUB_OVF_EN
    task automatic test_ovf;
        logic [W-1:0] ta[3] = '{8'h80, 8'h7F, 8'h05};
        logic [W-1:0] tb[3] = '{8'h01, 8'hFF, 8'h03};
        int           done_at, busy_cnt;
        exp_t         e;
        for (int k = 0; k < 3; k++) begin
            issue_op(ta[k], tb[k], 1'b0, 1'b1);
            wait_done(1'b0, -1, done_at, busy_cnt);
            e = sb.pop_front();
            checks++; if (d !== e.d || bout !== e.bout) begin errors++; $display("FAIL ovf_result[%0d]: got %h/%b expected %h/%b", k, d, bout, e.d, e.bout); end
            checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL ovf_flag[%0d]: got %b expected %b", k, ovf, e.ovf); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef SERSUB_OVF_EN
        test_ovf();
`endif
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
